tx_buffer_reader: RTL and testbench

//  Downstream consumer of buffer_memory. Given a command (start word address, word count,

---
 rtl/tx_buffer_reader_pkg.sv | 12 +
 rtl/tx_buffer_reader_skid_fifo2.sv | 31 +++
 rtl/tx_buffer_reader.sv | 85 ++++++++
 tb/tb_tx_buffer_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_buffer_reader_pkg.sv
// tx_buffer_reader_pkg: shared widths, FSM states and keep decode for the TX buffer reader.
package tx_buffer_reader_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W = 14;
  localparam logic [3:0] KEEP_ALL = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
  // Bytes fill from the MSB (network order); 0 means a full word.
  function automatic logic [3:0] keep_decode(input logic [1:0] lb);
    return lb == 2'd0 ? KEEP_ALL : ~(4'b1111 >> lb);
  endfunction
endpackage

// File: rtl/tx_buffer_reader_skid_fifo2.sv
// skid_fifo2: two-entry register FIFO with head register driving the output directly.
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_d0, r_d1;
  logic [1:0]   r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_count <= '0;
    end else begin
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      if (i_pop) r_d0 <= r_count == 2'd2 ? r_d1 : i_data;
      else if (i_push && r_count == 2'd0) r_d0 <= i_data;
      if (i_push && (r_count == 2'd2 || (r_count == 2'd1 && !i_pop))) r_d1 <= i_data;
    end
  end
  assign o_data = r_d0;
  assign o_valid = r_count != 2'd0;
  assign o_count = r_count;
endmodule

// File: rtl/tx_buffer_reader.sv
// tx_buffer_reader: reads a command's words from buffer memory and streams them out with backpressure.
module tx_buffer_reader
  import tx_buffer_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_last_bytes,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_keep,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [3:0]        r_keep;
  logic              r_inflight, r_inflight_last, r_done;
  logic              w_accept, w_pop, w_rd, w_fifo_valid;
  logic [1:0]        w_count;
  logic [DATA_W+4:0] w_head;
  // A read is only issued when its data is guaranteed a FIFO slot on arrival.
  always_comb begin
    cmd_ready = (r_state == S_IDLE) & ~reset;
    w_accept = cmd_valid & cmd_ready;
    w_pop = w_fifo_valid & m_ready;
    w_rd = (r_state == S_READ) && ({1'b0, r_inflight} + w_count - {1'b0, w_pop} < 2'd2);
    w_next = (r_state == S_IDLE && w_accept && cmd_len != '0) ? S_READ :
             (r_state == S_READ && w_rd && r_rem == LEN_W'(1)) ? S_DRAIN :
             (r_state == S_DRAIN && w_pop && m_last) ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_rem <= '0;
      r_keep <= '0;
      r_inflight <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inflight <= w_rd;
      r_inflight_last <= w_rd && r_rem == LEN_W'(1);
      r_done <= (w_pop & m_last) | (w_accept && cmd_len == '0);
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_rem <= cmd_len;
        r_keep <= keep_decode(cmd_last_bytes);
      end else if (w_rd) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end
  skid_fifo2 #(.W(DATA_W + 5)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  ({r_inflight_last, r_inflight_last ? r_keep : KEEP_ALL, mem_data}),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );
  assign mem_rd_en = w_rd;
  assign mem_addr_rd = r_addr;
  assign {m_last, m_keep, m_data} = w_head;
  assign m_valid = w_fifo_valid;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
endmodule

// File: tb/tb_tx_buffer_reader.sv
// tb_tx_buffer_reader: command-level model of the reader checked every cycle, plus directed literal checks.
module tb_tx_buffer_reader;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LW = 14;
  logic          clk = 0, reset = 1, cmd_valid = 0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0, mem_addr_rd;
  logic [LW-1:0] cmd_len = '0;
  logic [1:0]    cmd_last_bytes = '0;
  logic          mem_rd_en, m_valid, m_ready = 1, m_last, busy, done;
  logic [DW-1:0] mem_data = '0, m_data;
  logic [3:0]    m_keep;
  int total = 0, bad = 0, cyc = 0, rdy_mode = 0;
  int t_acc = 0, t_first = 0, t_done = 0;

  tx_buffer_reader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_last_bytes(cmd_last_bytes),
    .mem_rd_en(mem_rd_en), .mem_addr_rd(mem_addr_rd), .mem_data(mem_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  // Buffer memory stand-in: 1-cycle read latency, mem[a] = A0000000 + a.
  always @(posedge clk) if (mem_rd_en) mem_data <= 32'hA000_0000 + 32'(mem_addr_rd);
  always @(posedge clk) begin
    cyc++;
    #1;
    m_ready = rdy_mode == 0 ? 1'b1 : (cyc % 3 == 1);
  end

  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [31:0]   got_d[$];
  logic [3:0]    got_k[$];
  logic          got_l[$];
  logic [AW-1:0] got_a[$];
  logic          mbusy = 0, mdone = 0, prev_rst = 1, seen_valid = 0;
  logic [3:0]    keep_tab [4] = '{4'hF, 4'h8, 4'hC, 4'hE};

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic pop, acc;
    logic [AW-1:0] ai;
    word_t w;
    if (reset) begin
      chk("cmd_ready_in_reset", cmd_ready, 0);
      if (prev_rst) begin
        chk("rst_m_valid", m_valid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
      end
      exp_q.delete();
      addr_q.delete();
      mbusy = 0;
      mdone = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !mbusy);
      chk("busy", busy, mbusy);
      chk("done", done, mdone);
      if (done) t_done = cyc;
      chk("fifo_count_le2", 64'(dut.u_fifo.r_count <= 2'd2), 1);
      chk("m_valid_without_word", 64'(m_valid && exp_q.size() == 0), 0);
      if (mem_rd_en) begin
        if (addr_q.size() == 0) chk("spurious_read", 1, 0);
        else chk("rd_addr", mem_addr_rd, addr_q.pop_front());
        got_a.push_back(mem_addr_rd);
      end
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        t_first = cyc;
      end
      acc = cmd_valid && !mbusy;
      pop = m_valid && m_ready;
      mdone = 0;
      if (pop && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("m_data", m_data, w.d);
        chk("m_keep", m_keep, w.k);
        chk("m_last", m_last, w.l);
        got_d.push_back(m_data);
        got_k.push_back(m_keep);
        got_l.push_back(m_last);
        if (w.l) begin
          mbusy = 0;
          mdone = 1;
        end
      end
      if (acc) begin
        t_acc = cyc;
        seen_valid = 0;
        if (cmd_len == 0) mdone = 1;
        else begin
          mbusy = 1;
          for (int i = 0; i < int'(cmd_len); i++) begin
            ai = cmd_addr + AW'(i);
            addr_q.push_back(ai);
            w.d = 32'hA000_0000 + 32'(ai);
            w.l = i == int'(cmd_len) - 1;
            w.k = w.l ? keep_tab[cmd_last_bytes] : 4'hF;
            exp_q.push_back(w);
          end
        end
      end
    end
    prev_rst = reset;
  end

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] n, input logic [1:0] lb);
    got_d.delete();
    got_k.delete();
    got_l.delete();
    got_a.delete();
    @(posedge clk);
    #2;
    cmd_valid = 1;
    cmd_addr = a;
    cmd_len = n;
    cmd_last_bytes = lb;
    @(posedge clk);
    #2;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string n);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(n, 64'(k < 300), 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    reset = 0;
    @(negedge clk);
    chk("t1_m_valid", m_valid, 0);
    chk("t1_mem_rd_en", mem_rd_en, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_cmd_ready", cmd_ready, 1);

    send(14'h0010, 4, 2);
    wait_done("t2_done_seen");
    chk("t2_first_latency", t_first - t_acc, 3);
    chk("t2_done_latency", t_done - t_acc, 7);
    chk("t2_count", got_d.size(), 4);
    chk("t2_w0", got_d[0], 32'hA000_0010);
    chk("t2_w3", got_d[3], 32'hA000_0013);
    chk("t2_keep0", got_k[0], 4'hF);
    chk("t2_keep3", got_k[3], 4'hC);
    chk("t2_last0", got_l[0], 0);
    chk("t2_last3", got_l[3], 1);

    rdy_mode = 1;
    send(14'h0010, 4, 2);
    wait_done("t3_done_seen");
    rdy_mode = 0;
    chk("t3_count", got_d.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_word", got_d[i], 32'hA000_0010 + 32'(i));
    chk("t3_last3", got_l[3], 1);

    send(14'h3FFE, 4, 0);
    wait_done("t4_done_seen");
    chk("t4_a0", got_a[0], 14'h3FFE);
    chk("t4_a1", got_a[1], 14'h3FFF);
    chk("t4_a2", got_a[2], 14'h0000);
    chk("t4_a3", got_a[3], 14'h0001);
    chk("t4_w2", got_d[2], 32'hA000_0000);
    chk("t4_keep3", got_k[3], 4'hF);

    send(14'h0005, 0, 1);
    wait_done("t5_done_seen");
    chk("t5_done_latency", t_done - t_acc, 1);
    chk("t5_no_words", got_d.size(), 0);
    @(negedge clk);
    chk("t5_cmd_ready", cmd_ready, 1);

    send(14'h0020, 8, 3);
    for (int k = 0; k < 100 && got_d.size() < 2; k++) begin
      @(posedge clk);
      #2;
    end
    reset = 1;
    @(posedge clk);
    #2;
    reset = 0;
    @(negedge clk);
    chk("t6_m_valid_after_rst", m_valid, 0);
    chk("t6_no_done", done, 0);
    chk("t6_words_before_rst", got_d.size(), 2);
    send(14'h0100, 1, 0);
    wait_done("t6b_done_seen");
    chk("t6b_count", got_d.size(), 1);
    chk("t6b_w0", got_d[0], 32'hA000_0100);
    chk("t6b_keep", got_k[0], 4'hF);
    chk("t6b_last", got_l[0], 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
